axi_slave_ram: RTL and testbench
================================

Name:
axi_slave_ram

Overview:
Simulation-grade AXI3 slave memory model. It sits on the renderer's AXI master port in the Verilator top and backs all frame-buffer and texture traffic. Read and write channels are independent single-outstanding FSMs over one shared word array. A `memory_clear` task zero-fills the array.

Parameters:
ID_W, 4, width of AWID/WID/BID/ARID/RID
ADDR_W, 32, byte address width
LEN_W, 4, AXI3 burst length field width
DATA_W, 32, data bus width; strobe width is DATA_W/8
DEPTH_LOG2, 16, log2 of number of DATA_W-bit words

Ports:
clk_core  in  1  single clock, all logic on rising edge
rst_x  in  1  synchronous, active-high reset
i_awid/i_awaddr/i_awlen  in  ID_W/ADDR_W/LEN_W  write address, ID, beats-1
i_awsize/i_awburst/i_awlock/i_awcache/i_awprot  in  3/2/2/4/3  only i_awburst used (FIXED=0 holds address, else INCR)
i_awvalid  in  1  / o_awready out 1  write-address handshake
i_wid  in  ID_W  ignored
i_wdata/i_wstrb  in  DATA_W/DATA_W/8  write beat, byte enables
i_wlast  in  1  ignored; beat count terminates burst
i_wvalid  in 1 / o_wready  out 1  write-data handshake
o_bid  out  ID_W  latched AWID
o_bresp  out  2  always 2'b00 (OKAY)
o_bvalid  out 1 / i_bready  in 1  write-response handshake
i_arid/i_araddr/i_arlen  in  ID_W/ADDR_W/LEN_W  read request
i_arsize/i_arburst/i_arlock/i_arcache/i_arprot  in  3/2/2/4/3  only i_arburst used, same rule as AW
i_arvalid  in 1 / o_arready  out 1  read-address handshake
o_rid  out  ID_W  latched ARID
o_rdata  out  DATA_W  read beat
o_rresp  out  2  always 2'b00
o_rlast  out  1  high on final beat
o_rvalid  out 1 / i_rready  in 1  read-data handshake

Behaviour:
- Word index = addr[log2(DATA_W/8)+DEPTH_LOG2-1 : log2(DATA_W/8)]. Higher bits are dropped, so accesses wrap modulo DEPTH. Low byte-offset bits are ignored. All beats are full-width.
- The memory array is not reset. `memory_clear` (simulation task) writes 0 to every word.
- Write FSM has states W_IDLE, W_DATA and W_RESP.
  - W_IDLE: o_awready=1. On awvalid&awready, latch id, word address, len and burst type, clear the beat counter, and go to W_DATA.
  - W_DATA: o_wready=1. On each wvalid, write bytes whose strobe bit is 1; bytes with strobe 0 are unchanged. For INCR, address increments by 1 word per beat; FIXED holds it. On the beat where counter==len, go to W_RESP.
  - W_RESP: o_bvalid=1. On bready, return to W_IDLE.
- Read FSM has states R_IDLE and R_DATA.
  - R_IDLE: o_arready=1. On handshake, latch the request and go to R_DATA.
  - R_DATA: o_rvalid=1. o_rdata = mem[current address], combinational read. o_rlast = (counter==len). On rready the counter/address advance. On the last beat, return to R_IDLE.
- Latency:
  - First W beat is accepted in the cycle after the AW handshake.
  - First R beat is valid in the cycle after the AR handshake.
  - B response follows the last W beat by 1 cycle.
  - Full throughput of 1 beat/cycle.
- Valid signals are held high until their handshake completes; payload is stable while a valid is stalled.
- Simultaneous read and write to the same word in the same cycle: o_rdata shows the old value. The new value is visible the next cycle.
- Read and write channels operate fully concurrently. A new AW is accepted only after B completes; a new AR only after the last R beat.
- Reset (any time, including mid-burst): both FSMs go to IDLE. Already-written beats remain in memory.
- Output values while reset is asserted: o_awready=0, o_wready=0, o_bvalid=0, o_arready=0, o_rvalid=0, o_rlast=0, o_bid=0, o_rid=0.
- o_awready and o_arready rise to 1 in the first cycle after reset is released.

Test Plan:
- `memory_clear`, then AR addr 0x100 len 3 → four beats of 0; rlast only on beat 4; rid echoes arid=5.
- AW addr 0x40 len 0 id 3, W data 0xDEADBEEF strb 4'hF → bvalid, bid=3, bresp=0; read 0x40 returns 0xDEADBEEF.
- Write 0x11223344 to 0x40 with strb 4'b0101 over existing 0xDEADBEEF → readback 0xDE22BE44.
- INCR write len 7 at 0x200 with data 0..7, rready/wvalid toggled randomly, then read back → 0..7 in order, no lost or duplicated beats.
- Write at addr (DEPTH*4)+8 → readback at addr 8 returns the same data (wrap).
- Assert rst_x for 1 cycle mid read burst → rvalid drops next cycle, arready=1 after release; a new read completes correctly.

Source files
------------

// File: rtl/axi_slave_ram_if.sv
// rtl/axi_slave_ram_if.sv - AXI3 bus bundle between the renderer master and the RAM model
interface axi_slave_ram_if #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 4,
  parameter int DATA_W = 32
) ();
  // write address channel
  logic [ID_W-1:0]     i_awid;
  logic [ADDR_W-1:0]   i_awaddr;
  logic [LEN_W-1:0]    i_awlen;
  logic [2:0]          i_awsize;
  logic [1:0]          i_awburst;
  logic [1:0]          i_awlock;
  logic [3:0]          i_awcache;
  logic [2:0]          i_awprot;
  logic                i_awvalid;
  logic                o_awready;
  // write data channel
  logic [ID_W-1:0]     i_wid;
  logic [DATA_W-1:0]   i_wdata;
  logic [DATA_W/8-1:0] i_wstrb;
  logic                i_wlast;
  logic                i_wvalid;
  logic                o_wready;
  // write response channel
  logic [ID_W-1:0]     o_bid;
  logic [1:0]          o_bresp;
  logic                o_bvalid;
  logic                i_bready;
  // read address channel
  logic [ID_W-1:0]     i_arid;
  logic [ADDR_W-1:0]   i_araddr;
  logic [LEN_W-1:0]    i_arlen;
  logic [2:0]          i_arsize;
  logic [1:0]          i_arburst;
  logic [1:0]          i_arlock;
  logic [3:0]          i_arcache;
  logic [2:0]          i_arprot;
  logic                i_arvalid;
  logic                o_arready;
  // read data channel
  logic [ID_W-1:0]     o_rid;
  logic [DATA_W-1:0]   o_rdata;
  logic [1:0]          o_rresp;
  logic                o_rlast;
  logic                o_rvalid;
  logic                i_rready;

  modport slave (
    input  i_awid, i_awaddr, i_awlen, i_awsize, i_awburst, i_awlock, i_awcache, i_awprot, i_awvalid,
    output o_awready,
    input  i_wid, i_wdata, i_wstrb, i_wlast, i_wvalid,
    output o_wready,
    output o_bid, o_bresp, o_bvalid,
    input  i_bready,
    input  i_arid, i_araddr, i_arlen, i_arsize, i_arburst, i_arlock, i_arcache, i_arprot, i_arvalid,
    output o_arready,
    output o_rid, o_rdata, o_rresp, o_rlast, o_rvalid,
    input  i_rready
  );

  modport master (
    output i_awid, i_awaddr, i_awlen, i_awsize, i_awburst, i_awlock, i_awcache, i_awprot, i_awvalid,
    input  o_awready,
    output i_wid, i_wdata, i_wstrb, i_wlast, i_wvalid,
    input  o_wready,
    input  o_bid, o_bresp, o_bvalid,
    output i_bready,
    output i_arid, i_araddr, i_arlen, i_arsize, i_arburst, i_arlock, i_arcache, i_arprot, i_arvalid,
    input  o_arready,
    input  o_rid, o_rdata, o_rresp, o_rlast, o_rvalid,
    output i_rready
  );
endinterface

// File: rtl/axi_slave_ram.sv
// rtl/axi_slave_ram.sv - AXI3 slave RAM model with independent single-outstanding read/write FSMs
module axi_slave_ram #(
  parameter int ID_W       = 4,
  parameter int ADDR_W     = 32,
  parameter int LEN_W      = 4,
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 16
) (
  input  logic            clk_core,
  input  logic            rst_x,
  axi_slave_ram_if.slave  bus
);
  localparam int STRB_W = DATA_W / 8;
  localparam int OFF    = $clog2(STRB_W);
  localparam int DEPTH  = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  w_state_t              w_state, w_next;
  logic [ID_W-1:0]       w_id;
  logic [DEPTH_LOG2-1:0] w_addr;
  logic [LEN_W-1:0]      w_len, w_cnt;
  logic                  w_fixed;

  r_state_t              r_state, r_next;
  logic [ID_W-1:0]       r_id;
  logic [DEPTH_LOG2-1:0] r_addr;
  logic [LEN_W-1:0]      r_len, r_cnt;
  logic                  r_fixed;

  logic aw_fire, w_fire, r_fire, ar_fire;

  // Zero-fills the array; meant to be called while the bus is idle.
  task automatic memory_clear();
    for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
  endtask

  // Write FSM next state and channel outputs; everything is forced quiet during reset.
  always_comb begin
    w_next        = w_state;
    bus.o_awready = 1'b0;
    bus.o_wready  = 1'b0;
    bus.o_bvalid  = 1'b0;
    bus.o_bid     = '0;
    bus.o_bresp   = 2'b00;
    if (!rst_x) begin
      bus.o_bid = w_id;
      case (w_state)
        W_IDLE: begin
          bus.o_awready = 1'b1;
          if (bus.i_awvalid) w_next = W_DATA;
        end
        W_DATA: begin
          bus.o_wready = 1'b1;
          if (bus.i_wvalid && (w_cnt == w_len)) w_next = W_RESP;
        end
        W_RESP: begin
          bus.o_bvalid = 1'b1;
          if (bus.i_bready) w_next = W_IDLE;
        end
        default: w_next = W_IDLE;
      endcase
    end
  end

  assign aw_fire = bus.o_awready & bus.i_awvalid;
  assign w_fire  = bus.o_wready & bus.i_wvalid;

  // Write FSM state register and burst bookkeeping.
  always_ff @(posedge clk_core) begin
    if (rst_x) begin
      w_state <= W_IDLE;
      w_id    <= '0;
      w_addr  <= '0;
      w_len   <= '0;
      w_cnt   <= '0;
      w_fixed <= 1'b0;
    end else begin
      w_state <= w_next;
      if (aw_fire) begin
        w_id    <= bus.i_awid;
        w_addr  <= bus.i_awaddr[OFF+DEPTH_LOG2-1:OFF];
        w_len   <= bus.i_awlen;
        w_cnt   <= '0;
        w_fixed <= (bus.i_awburst == 2'b00);
      end else if (w_fire) begin
        w_cnt <= w_cnt + 1'b1;
        if (!w_fixed) w_addr <= w_addr + 1'b1;
      end
    end
  end

  // Byte-masked array write; the array itself is never reset.
  always_ff @(posedge clk_core) begin
    if (w_fire) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (bus.i_wstrb[b]) mem[w_addr][b*8 +: 8] <= bus.i_wdata[b*8 +: 8];
      end
    end
  end

  // Read FSM next state and channel outputs; rdata is a combinational array read.
  always_comb begin
    r_next        = r_state;
    bus.o_arready = 1'b0;
    bus.o_rvalid  = 1'b0;
    bus.o_rlast   = 1'b0;
    bus.o_rid     = '0;
    bus.o_rresp   = 2'b00;
    bus.o_rdata   = mem[r_addr];
    if (!rst_x) begin
      bus.o_rid = r_id;
      case (r_state)
        R_IDLE: begin
          bus.o_arready = 1'b1;
          if (bus.i_arvalid) r_next = R_DATA;
        end
        R_DATA: begin
          bus.o_rvalid = 1'b1;
          bus.o_rlast  = (r_cnt == r_len);
          if (bus.i_rready && (r_cnt == r_len)) r_next = R_IDLE;
        end
        default: r_next = R_IDLE;
      endcase
    end
  end

  assign ar_fire = bus.o_arready & bus.i_arvalid;
  assign r_fire  = bus.o_rvalid & bus.i_rready;

  // Read FSM state register and burst bookkeeping.
  always_ff @(posedge clk_core) begin
    if (rst_x) begin
      r_state <= R_IDLE;
      r_id    <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_fixed <= 1'b0;
    end else begin
      r_state <= r_next;
      if (ar_fire) begin
        r_id    <= bus.i_arid;
        r_addr  <= bus.i_araddr[OFF+DEPTH_LOG2-1:OFF];
        r_len   <= bus.i_arlen;
        r_cnt   <= '0;
        r_fixed <= (bus.i_arburst == 2'b00);
      end else if (r_fire) begin
        r_cnt <= r_cnt + 1'b1;
        if (!r_fixed) r_addr <= r_addr + 1'b1;
      end
    end
  end

  // Fields the model deliberately ignores.
  logic unused_bits;
  assign unused_bits = ^{bus.i_awsize, bus.i_awlock, bus.i_awcache, bus.i_awprot,
                         bus.i_arsize, bus.i_arlock, bus.i_arcache, bus.i_arprot,
                         bus.i_wid, bus.i_wlast,
                         bus.i_awaddr[ADDR_W-1:OFF+DEPTH_LOG2], bus.i_awaddr[OFF-1:0],
                         bus.i_araddr[ADDR_W-1:OFF+DEPTH_LOG2], bus.i_araddr[OFF-1:0]};
endmodule

// File: tb/tb_axi_slave_ram.sv
// tb/tb_axi_slave_ram.sv - directed self-checking bench for axi_slave_ram
module tb_axi_slave_ram;
  logic clk_core = 1'b0;
  logic rst_x    = 1'b1;

  axi_slave_ram_if bus ();

  axi_slave_ram dut (
    .clk_core (clk_core),
    .rst_x    (rst_x),
    .bus      (bus)
  );

  always #5 clk_core = ~clk_core;

  int checks = 0;
  int errors = 0;

  logic [31:0] wd_q [0:7];
  logic [3:0]  ws_q [0:7];
  logic [31:0] rd_q [0:7];
  logic        rl_q [0:7];
  logic [3:0]  rid_got;
  logic [3:0]  bid_got;
  logic [1:0]  bresp_got;
  logic [1:0]  rresp_got;

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [3:0]  id;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [0:7];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting on DUT", name);
  endtask

  // Entered and left just after a falling edge.
  task automatic axi_write(input logic [31:0] addr, input int len, input logic [1:0] burst,
                           input logic [3:0] id, input bit rnd);
    int n;
    int t;
    bus.i_awvalid = 1'b1;
    bus.i_awaddr  = addr;
    bus.i_awlen   = 4'(len);
    bus.i_awburst = burst;
    bus.i_awid    = id;
    t = 0;
    while (!bus.o_awready && t < 50) begin @(negedge clk_core); t++; end
    if (t >= 50) timeout_fail("aw_handshake");
    @(negedge clk_core);
    bus.i_awvalid = 1'b0;
    check("w_first_ready", 32'(bus.o_wready), 32'd1);
    n = 0;
    t = 0;
    while (n <= len && t < 300) begin
      bus.i_wvalid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.i_wdata  = wd_q[n];
      bus.i_wstrb  = ws_q[n];
      bus.i_wlast  = (n == len);
      if (bus.i_wvalid && bus.o_wready) n++;
      @(negedge clk_core);
      t++;
    end
    bus.i_wvalid = 1'b0;
    if (t >= 300) timeout_fail("w_beats");
    check("b_latency", 32'(bus.o_bvalid), 32'd1);
    bid_got   = bus.o_bid;
    bresp_got = bus.o_bresp;
    bus.i_bready = 1'b1;
    @(negedge clk_core);
    bus.i_bready = 1'b0;
    check("b_done_awready", 32'(bus.o_awready), 32'd1);
  endtask

  // Entered and left just after a falling edge.
  task automatic axi_read(input logic [31:0] addr, input int len, input logic [1:0] burst,
                          input logic [3:0] id, input bit rnd);
    int n;
    int t;
    bus.i_arvalid = 1'b1;
    bus.i_araddr  = addr;
    bus.i_arlen   = 4'(len);
    bus.i_arburst = burst;
    bus.i_arid    = id;
    t = 0;
    while (!bus.o_arready && t < 50) begin @(negedge clk_core); t++; end
    if (t >= 50) timeout_fail("ar_handshake");
    @(negedge clk_core);
    bus.i_arvalid = 1'b0;
    check("r_first_valid", 32'(bus.o_rvalid), 32'd1);
    n = 0;
    t = 0;
    while (n <= len && t < 300) begin
      bus.i_rready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bus.i_rready && bus.o_rvalid) begin
        rd_q[n]   = bus.o_rdata;
        rl_q[n]   = bus.o_rlast;
        rid_got   = bus.o_rid;
        rresp_got = bus.o_rresp;
        n++;
      end
      @(negedge clk_core);
      t++;
    end
    bus.i_rready = 1'b0;
    if (t >= 300) timeout_fail("r_beats");
    check("r_done_rvalid", 32'(bus.o_rvalid), 32'd0);
    check("r_done_arready", 32'(bus.o_arready), 32'd1);
  endtask

  initial begin
    bus.i_awid = '0; bus.i_awaddr = '0; bus.i_awlen = '0; bus.i_awsize = 3'd2;
    bus.i_awburst = 2'b01; bus.i_awlock = '0; bus.i_awcache = '0; bus.i_awprot = '0;
    bus.i_awvalid = 1'b0;
    bus.i_wid = '0; bus.i_wdata = '0; bus.i_wstrb = '0; bus.i_wlast = 1'b0; bus.i_wvalid = 1'b0;
    bus.i_bready = 1'b0;
    bus.i_arid = '0; bus.i_araddr = '0; bus.i_arlen = '0; bus.i_arsize = 3'd2;
    bus.i_arburst = 2'b01; bus.i_arlock = '0; bus.i_arcache = '0; bus.i_arprot = '0;
    bus.i_arvalid = 1'b0;
    bus.i_rready = 1'b0;

    // single-beat {write/read} vectors, applied in order over a cleared array
    vecs[0] = '{1'b1, 32'h0000_0040, 4'd3, 32'hDEAD_BEEF, 4'hF,    32'h0};
    vecs[1] = '{1'b0, 32'h0000_0040, 4'd1, 32'h0,         4'h0,    32'hDEAD_BEEF};
    vecs[2] = '{1'b1, 32'h0000_0040, 4'd2, 32'h1122_3344, 4'b0101, 32'h0};
    vecs[3] = '{1'b0, 32'h0000_0040, 4'd6, 32'h0,         4'h0,    32'hDE22_BE44};
    vecs[4] = '{1'b1, 32'h0004_0008, 4'd7, 32'hA5A5_0001, 4'hF,    32'h0};
    vecs[5] = '{1'b0, 32'h0000_0008, 4'd9, 32'h0,         4'h0,    32'hA5A5_0001};
    vecs[6] = '{1'b1, 32'h0000_0047, 4'd4, 32'hFF12_3456, 4'b1000, 32'h0};
    vecs[7] = '{1'b0, 32'h0000_0046, 4'd8, 32'h0,         4'h0,    32'hFF00_0000};

    // reset state
    repeat (2) @(negedge clk_core);
    check("rst_awready", 32'(bus.o_awready), 32'd0);
    check("rst_wready",  32'(bus.o_wready),  32'd0);
    check("rst_bvalid",  32'(bus.o_bvalid),  32'd0);
    check("rst_arready", 32'(bus.o_arready), 32'd0);
    check("rst_rvalid",  32'(bus.o_rvalid),  32'd0);
    check("rst_rlast",   32'(bus.o_rlast),   32'd0);
    check("rst_bid",     32'(bus.o_bid),     32'd0);
    check("rst_rid",     32'(bus.o_rid),     32'd0);
    rst_x = 1'b0;
    @(negedge clk_core);
    check("rel_awready", 32'(bus.o_awready), 32'd1);
    check("rel_arready", 32'(bus.o_arready), 32'd1);

    dut.memory_clear();
    @(negedge clk_core);

    // cleared memory reads back zero, rlast only on the fourth beat, rid echoes
    axi_read(32'h100, 3, 2'b01, 4'd5, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("clr_data%0d", i), rd_q[i], 32'h0);
      check($sformatf("clr_rlast%0d", i), 32'(rl_q[i]), (i == 3) ? 32'd1 : 32'd0);
    end
    check("clr_rid", 32'(rid_got), 32'd5);
    check("clr_rresp", 32'(rresp_got), 32'd0);

    // table of single-beat writes and readbacks
    for (int v = 0; v < 8; v++) begin
      if (vecs[v].is_wr) begin
        wd_q[0] = vecs[v].data;
        ws_q[0] = vecs[v].strb;
        axi_write(vecs[v].addr, 0, 2'b01, vecs[v].id, 1'b0);
        check($sformatf("vec%0d_bid", v), 32'(bid_got), 32'(vecs[v].id));
        check($sformatf("vec%0d_bresp", v), 32'(bresp_got), 32'd0);
      end else begin
        axi_read(vecs[v].addr, 0, 2'b01, vecs[v].id, 1'b0);
        check($sformatf("vec%0d_rdata", v), rd_q[0], vecs[v].exp);
        check($sformatf("vec%0d_rid", v), 32'(rid_got), 32'(vecs[v].id));
        check($sformatf("vec%0d_rlast", v), 32'(rl_q[0]), 32'd1);
      end
    end

    // INCR burst of 8 with random wvalid, read back with random rready
    for (int i = 0; i < 8; i++) begin wd_q[i] = 32'(i); ws_q[i] = 4'hF; end
    axi_write(32'h200, 7, 2'b01, 4'd10, 1'b1);
    check("incr_bid", 32'(bid_got), 32'd10);
    axi_read(32'h200, 7, 2'b01, 4'd11, 1'b1);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("incr_data%0d", i), rd_q[i], 32'(i));
      check($sformatf("incr_rlast%0d", i), 32'(rl_q[i]), (i == 7) ? 32'd1 : 32'd0);
    end

    // FIXED burst: all three beats land on one word, neighbour untouched
    wd_q[0] = 32'h1; wd_q[1] = 32'h2; wd_q[2] = 32'h3;
    ws_q[0] = 4'hF;  ws_q[1] = 4'hF;  ws_q[2] = 4'hF;
    axi_write(32'h300, 2, 2'b00, 4'd12, 1'b0);
    axi_read(32'h300, 0, 2'b01, 4'd0, 1'b0);
    check("fixed_word", rd_q[0], 32'h3);
    axi_read(32'h304, 0, 2'b01, 4'd0, 1'b0);
    check("fixed_next", rd_q[0], 32'h0);
    // FIXED read repeats the same word
    axi_read(32'h204, 2, 2'b00, 4'd2, 1'b0);
    for (int i = 0; i < 3; i++) check($sformatf("fixed_rd%0d", i), rd_q[i], 32'h1);

    // reset in the middle of a read burst
    bus.i_arvalid = 1'b1; bus.i_araddr = 32'h200; bus.i_arlen = 4'd7;
    bus.i_arburst = 2'b01; bus.i_arid = 4'd13;
    @(negedge clk_core);
    bus.i_arvalid = 1'b0;
    bus.i_rready  = 1'b1;
    check("mid_beat0", bus.o_rdata, 32'h0);
    @(negedge clk_core);
    check("mid_beat1", bus.o_rdata, 32'h1);
    check("mid_rid", 32'(bus.o_rid), 32'd13);
    @(negedge clk_core);
    bus.i_rready = 1'b0;
    rst_x = 1'b1;
    @(negedge clk_core);
    check("mid_rst_rvalid",  32'(bus.o_rvalid),  32'd0);
    check("mid_rst_arready", 32'(bus.o_arready), 32'd0);
    check("mid_rst_rid",     32'(bus.o_rid),     32'd0);
    rst_x = 1'b0;
    @(negedge clk_core);
    check("mid_rel_arready", 32'(bus.o_arready), 32'd1);
    check("mid_rel_rvalid",  32'(bus.o_rvalid),  32'd0);
    axi_read(32'h208, 3, 2'b01, 4'd14, 1'b0);
    for (int i = 0; i < 4; i++) check($sformatf("post_rst_data%0d", i), rd_q[i], 32'(i + 2));
    check("post_rst_rid", 32'(rid_got), 32'd14);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end
endmodule
